// File: rtl/stopwatch_pkg.sv
//------------------------------------------------------------------------------
// Module   : stopwatch_pkg
// Brief    : Shared types and constants for the BCD minutes:seconds stopwatch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

   // Control state of the stopwatch.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } sw_state_t;

   // One packed BCD digit.
   typedef logic [3:0] bcd_t;

   // Highest value held by the seconds-tens digit.
   localparam bcd_t SEC_TENS_MAX = 4'd5;
   // Highest value held by any other digit.
   localparam bcd_t DIGIT_MAX    = 4'd9;

   // Roll-over value of digit position idx (0 = sec units ... 3 = min tens).
   function automatic bcd_t digit_max(input int idx);
      return (idx == 1) ? SEC_TENS_MAX : DIGIT_MAX;
   endfunction

endpackage : stopwatch_pkg

`default_nettype wire

// File: rtl/bcd_digit.sv
//------------------------------------------------------------------------------
// Module   : bcd_digit
// Brief    : Single BCD counter digit that rolls over after MAX and raises a
//            combinational carry on the increment that causes the roll-over.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter bcd_t MAX = DIGIT_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output bcd_t value,
   output logic carry
);

   bcd_t r_value;

   // Digit register: clear has priority over increment, wrap after MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= '0;
      end else if (clr) begin
         r_value <= '0;
      end else if (inc) begin
         r_value <= (r_value == MAX) ? 4'd0 : r_value + 4'd1;
      end
   end

   assign value = r_value;
   assign carry = inc && (r_value == MAX);

endmodule : bcd_digit

`default_nettype wire

// File: rtl/stopwatch_bcd.sv
//------------------------------------------------------------------------------
// Module   : stopwatch_bcd
// Brief    : BCD minutes:seconds stopwatch driven by a one-cycle tick pulse,
//            with start/stop and clear control, wrap or saturate at the top
//            count. Optional lap freeze enabled by macro STOPWATCH_LAP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN  = 59,
   parameter bit SATURATE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        start_stop,
   input  logic        clear,
`ifdef STOPWATCH_LAP_EN
   input  logic        lap,
   output logic        lap_active,
`endif
   output logic [15:0] digits,
   output logic        running,
   output logic        rollover
);

   // Top minutes value split into its two BCD digits.
   localparam bcd_t C_MAX_MIN_TENS  = bcd_t'(MAX_MIN / 10);
   localparam bcd_t C_MAX_MIN_UNITS = bcd_t'(MAX_MIN % 10);

   sw_state_t   r_state;
   sw_state_t   w_state_next;
   logic        r_rollover;

   bcd_t        w_digit [4];   // 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens
   logic [3:0]  w_inc;
   logic [3:0]  w_carry;
   logic        w_unused_top_carry;

   logic        w_tick_run;
   logic        w_at_max;
   logic        w_count_en;
   logic        w_wrap;
   logic        w_zero;
   logic [15:0] w_live;

   assign w_tick_run = (r_state == RUN) && tick;
   assign w_at_max   = (w_digit[3] == C_MAX_MIN_TENS)  &&
                       (w_digit[2] == C_MAX_MIN_UNITS) &&
                       (w_digit[1] == SEC_TENS_MAX)    &&
                       (w_digit[0] == DIGIT_MAX);

   // At the top count the chain is never incremented; wrap clears it instead.
   assign w_count_en = w_tick_run && !w_at_max;
   assign w_wrap     = w_tick_run && w_at_max && !SATURATE;
   // Clear only acts outside RUN; in RUN start_stop owns the cycle.
   assign w_zero     = ((r_state != RUN) && clear) || w_wrap;

   // The minutes-tens carry can never fire because the top-count check stops
   // counting first; it is tied off here.
   assign w_unused_top_carry = w_carry[3];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign w_inc[gi] = w_count_en;
         end else begin : g_chain
            assign w_inc[gi] = w_carry[gi-1];
         end

         bcd_digit #(
            .MAX (digit_max(gi))
         ) u_digit (
            .clk   (clk),
            .rst   (rst),
            .inc   (w_inc[gi]),
            .clr   (w_zero),
            .value (w_digit[gi]),
            .carry (w_carry[gi])
         );
      end
   endgenerate

   assign w_live = {w_digit[3], w_digit[2], w_digit[1], w_digit[0]};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: clear beats start outside RUN, start_stop beats clear in RUN.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (!clear && start_stop) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (start_stop || (w_tick_run && w_at_max && SATURATE)) begin
               w_state_next = PAUSED;
            end
         end
         PAUSED: begin
            if (clear) begin
               w_state_next = IDLE;
            end else if (start_stop) begin
               w_state_next = RUN;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Rollover pulse lines up with the first cycle showing the wrapped/held count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rollover <= 1'b0;
      end else begin
         r_rollover <= w_tick_run && w_at_max;
      end
   end

   assign running  = (r_state == RUN);
   assign rollover = r_rollover;

`ifdef STOPWATCH_LAP_EN
   logic        r_lap_active;
   logic [15:0] r_snapshot;

   // Lap freeze: toggled by lap in RUN, released when heading to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lap_active <= 1'b0;
         r_snapshot   <= '0;
      end else if (w_state_next == IDLE) begin
         r_lap_active <= 1'b0;
      end else if ((r_state == RUN) && lap) begin
         r_lap_active <= !r_lap_active;
         if (!r_lap_active) begin
            r_snapshot <= w_live;
         end
      end
   end

   assign lap_active = r_lap_active;
   assign digits     = r_lap_active ? r_snapshot : w_live;
`else
   assign digits     = w_live;
`endif

endmodule : stopwatch_bcd

`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
//------------------------------------------------------------------------------
// Module   : tb_stopwatch_bcd
// Brief    : Self-checking bench for stopwatch_bcd. Two instances run in
//            lock-step: one wrapping (SATURATE=0) and one saturating
//            (SATURATE=1). A seconds-based reference model pushes expected
//            outputs into a scoreboard each cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_bcd;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] digits0, digits1;
   logic        running0, running1;
   logic        rollover0, rollover1;
`ifdef STOPWATCH_LAP_EN
   logic        lap = 1'b0;
   logic        lap_active0, lap_active1;
`endif

   always #5 clk = ~clk;

   stopwatch_bcd #(.MAX_MIN(59), .SATURATE(1'b0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start_stop (start_stop),
      .clear      (clear),
`ifdef STOPWATCH_LAP_EN
      .lap        (lap),
      .lap_active (lap_active0),
`endif
      .digits     (digits0),
      .running    (running0),
      .rollover   (rollover0)
   );

   stopwatch_bcd #(.MAX_MIN(59), .SATURATE(1'b1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start_stop (start_stop),
      .clear      (clear),
`ifdef STOPWATCH_LAP_EN
      .lap        (lap),
      .lap_active (lap_active1),
`endif
      .digits     (digits1),
      .running    (running1),
      .rollover   (rollover1)
   );

   typedef struct {
      logic [15:0] dig;
      logic        run;
      logic        roll;
      logic        lapa;
   } exp_t;

   exp_t sb[$];

   // Reference model: 0 idle, 1 run, 2 paused; count as total seconds.
   int m_state [2];
   int m_secs  [2];
   int m_snap  [2];
   bit m_lap   [2];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [15:0] to_bcd(input int s);
      int m;
      int x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0;
         m_secs[k]  = 0;
         m_snap[k]  = 0;
         m_lap[k]   = 1'b0;
      end
      sb.delete();
   endtask

   task automatic model_step(input bit t, input bit ss, input bit cl, input bit lp);
      for (int k = 0; k < 2; k++) begin
         int st;
         int ns;
         int secs;
         bit roll;
         st   = m_state[k];
         ns   = st;
         secs = m_secs[k];
         roll = 1'b0;
         if (st == 1 && t) begin
            if (secs == 3599) begin
               roll = 1'b1;
               if (k == 1) ns = 2;
               else        secs = 0;
            end else begin
               secs = secs + 1;
            end
         end
         case (st)
            0: if (!cl && ss) ns = 1;
            1: if (ss) ns = 2;
            2: if (cl) ns = 0; else if (ss) ns = 1;
            default: ns = 0;
         endcase
         if (ns == 0) secs = 0;
         if (st == 1 && lp) begin
            if (m_lap[k]) begin
               m_lap[k] = 1'b0;
            end else begin
               m_lap[k]  = 1'b1;
               m_snap[k] = m_secs[k];
            end
         end
         if (ns == 0) m_lap[k] = 1'b0;
         m_state[k] = ns;
         m_secs[k]  = secs;
         sb.push_back('{dig: to_bcd(m_lap[k] ? m_snap[k] : secs), run: (ns == 1),
                        roll: roll, lapa: m_lap[k]});
      end
   endtask

   // Drive one cycle of inputs, predict, then compare once the edge has passed.
   task automatic step(input bit t, input bit ss, input bit cl, input bit lp);
      exp_t        e;
      logic [15:0] gd;
      logic        gr, gro;
      tick       = t;
      start_stop = ss;
      clear      = cl;
`ifdef STOPWATCH_LAP_EN
      lap        = lp;
`endif
      model_step(t, ss, cl, lp);
      @(posedge clk);
      #1;
      tick       = 1'b0;
      start_stop = 1'b0;
      clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap        = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
         e   = sb.pop_front();
         gd  = (k == 0) ? digits0   : digits1;
         gr  = (k == 0) ? running0  : running1;
         gro = (k == 0) ? rollover0 : rollover1;
         n_tests++;
         if (gd !== e.dig) begin
            n_fail++;
            $display("FAIL sb_digits dut%0d t=%0t: got %h expected %h", k, $time, gd, e.dig);
         end
         n_tests++;
         if (gr !== e.run) begin
            n_fail++;
            $display("FAIL sb_running dut%0d t=%0t: got %b expected %b", k, $time, gr, e.run);
         end
         n_tests++;
         if (gro !== e.roll) begin
            n_fail++;
            $display("FAIL sb_rollover dut%0d t=%0t: got %b expected %b", k, $time, gro, e.roll);
         end
`ifdef STOPWATCH_LAP_EN
         n_tests++;
         if (((k == 0) ? lap_active0 : lap_active1) !== e.lapa) begin
            n_fail++;
            $display("FAIL sb_lap_active dut%0d t=%0t: got %b expected %b", k, $time,
                     (k == 0) ? lap_active0 : lap_active1, e.lapa);
         end
`endif
      end
   endtask

   // Asynchronous reset applied mid-cycle.
   task automatic do_reset();
      #3;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (digits0 !== 16'h0000 || digits1 !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_digits: got %h/%h expected 0000", digits0, digits1);
      end
      n_tests++;
      if (running0 !== 1'b0 || running1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_running: got %b/%b expected 0", running0, running1);
      end
      n_tests++;
      if (rollover0 !== 1'b0 || rollover1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rollover: got %b/%b expected 0", rollover0, rollover1);
      end
      rst = 1'b0;
      model_reset();
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midcount();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (754) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits0 !== 16'h1234 || running0 !== 1'b1) begin
         n_fail++;
         $display("FAIL midcount_1234: got %h run %b expected 1234 run 1", digits0, running0);
      end
      do_reset();
      n_tests++;
      if (digits0 !== 16'h0000 || running0 !== 1'b0 || digits1 !== 16'h0000) begin
         n_fail++;
         $display("FAIL midcount_reset: got %h/%h run %b expected 0000 run 0",
                  digits0, digits1, running0);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits0 !== 16'h0000) begin
         n_fail++;
         $display("FAIL idle_tick_ignored: got %h expected 0000", digits0);
      end
   endtask

   task automatic test_carry();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (60) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits0 !== 16'h0100) begin
         n_fail++;
         $display("FAIL carry_60: got %h expected 0100", digits0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits0 !== 16'h0101) begin
         n_fail++;
         $display("FAIL carry_61: got %h expected 0101", digits0);
      end
   endtask

   task automatic test_max();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3599) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits0 !== 16'h5959 || digits1 !== 16'h5959) begin
         n_fail++;
         $display("FAIL max_preload: got %h/%h expected 5959", digits0, digits1);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits0 !== 16'h0000 || rollover0 !== 1'b1 || running0 !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap: got %h roll %b run %b expected 0000 roll 1 run 1",
                  digits0, rollover0, running0);
      end
      n_tests++;
      if (digits1 !== 16'h5959 || rollover1 !== 1'b1 || running1 !== 1'b0) begin
         n_fail++;
         $display("FAIL saturate: got %h roll %b run %b expected 5959 roll 1 run 0",
                  digits1, rollover1, running1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (rollover0 !== 1'b0 || rollover1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rollover_width: got %b/%b expected 0", rollover0, rollover1);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits1 !== 16'h5959 || digits0 !== 16'h0001) begin
         n_fail++;
         $display("FAIL post_max_tick: got %h/%h expected 0001/5959", digits0, digits1);
      end
   endtask

   task automatic test_clear_start();
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (digits0 !== 16'h0000 || running0 !== 1'b0) begin
         n_fail++;
         $display("FAIL paused_clear_start: got %h run %b expected 0000 run 0", digits0, running0);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (digits0 !== 16'h0007 || running0 !== 1'b0) begin
         n_fail++;
         $display("FAIL run_clear_start: got %h run %b expected 0007 run 0", digits0, running0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (digits0 !== 16'h0005 || lap_active0 !== 1'b1) begin
         n_fail++;
         $display("FAIL lap_freeze: got %h lap %b expected 0005 lap 1", digits0, lap_active0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (digits0 !== 16'h0008 || lap_active0 !== 1'b0) begin
         n_fail++;
         $display("FAIL lap_release: got %h lap %b expected 0008 lap 0", digits0, lap_active0);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_reset_midcount();
      test_carry();
      test_max();
      test_clear_start();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule : tb_stopwatch_bcd

`default_nettype wire

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Downstream consumer of the tick divider's terminal-count pulse. Counts one-cycle `tick` pulses as elapsed time in BCD minutes:seconds (00:00 to 59:59). Start/stop and clear are controlled through a three-state machine. Drives four packed BCD digits to the seven-segment decoders on the DE10 board.

## Interface
- `MAX_MIN`, default 59: highest minutes value, in BCD tens/units form. Legal range 1–99.
- `SATURATE`, default 0: behaviour at the maximum count.
  - 0: wrap to 00:00.
  - 1: hold at max and pause.
- `clk  input  1`: system clock, 50 MHz.
- `rst  input  1`: reset. Asynchronous, active-high.
- `tick  input  1`: one-cycle count pulse, normally the divider's `tc`. At most one per clock.
- `start_stop  input  1`: one-cycle pulse, already debounced/edge-detected upstream.
- `clear  input  1`: one-cycle pulse.
- `lap  input  1`: lap toggle pulse. Present only with `STOPWATCH_LAP_EN`.
- `digits  output  16`: BCD `{min_tens, min_units, sec_tens, sec_units}`; `[15:12]` is `min_tens`.
- `running  output  1`: high while in RUN.
- `rollover  output  1`: one-cycle pulse on wrap or on reaching saturation.
- `lap_active  output  1`: high while the display is frozen. Present only with `STOPWATCH_LAP_EN`.

## Operation
- States and transitions:
  - IDLE: count zero.
  - RUN: count advances on `tick`.
  - PAUSED: count held.
  - IDLE + `start_stop` → RUN.
  - RUN + `start_stop` → PAUSED.
  - PAUSED + `start_stop` → RUN.
  - PAUSED or IDLE + `clear` → IDLE, count zeroed.
- `clear` in RUN is ignored.
- Simultaneous `start_stop` and `clear`:
  - In IDLE/PAUSED, `clear` wins: go to IDLE, zero the count, no start.
  - In RUN, `start_stop` wins and `clear` is ignored.
- Count advance, per `tick` in RUN:
  - `sec_units` 0–9; carry into `sec_tens` 0–5.
  - Carry into `min_units` 0–9; carry into `min_tens` 0–9.
  - Minutes are bounded by `MAX_MIN`.
  - No digit ever holds a value above 9, and `sec_tens` never exceeds 5.
- `tick` and `start_stop` in the same RUN cycle: the tick is counted, then the state goes to PAUSED.
- `tick` outside RUN is discarded. It is not queued.
- At max (`MAX_MIN`:59) with a `tick` in RUN:
  - `SATURATE`=0: count becomes 00:00, `rollover` pulses, state stays RUN.
  - `SATURATE`=1: count stays at max, `rollover` pulses, state goes to PAUSED.
  - Further ticks while held at max are ignored.
- Reset (any time, mid-count included): state IDLE, count 00:00, `digits`=16'h0000, `running`=0, `rollover`=0, `lap_active`=0.

## Timing
- All outputs are registered or decoded from registers. No combinational path from inputs to outputs.
- `digits` reflects a tick one cycle after the `tick` edge is sampled.
- `rollover` is asserted in the same cycle that `digits` first shows the wrapped or saturated value. It lasts exactly one cycle.
- `running` changes one cycle after the `start_stop` sample.
- Maximum tick rate is one per clock. Back-to-back ticks each advance the count by exactly one.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - Adds the `lap` input and `lap_active` output.
  - `lap` in RUN toggles freeze. While frozen, `digits` shows a snapshot taken on the `lap` cycle and the internal count keeps advancing.
  - A second `lap` releases the freeze; `digits` returns to the live count the next cycle.
  - `lap` outside RUN is ignored.
  - Entering IDLE or applying reset releases the freeze.
  - PAUSED keeps the freeze.
- Undefined: no `lap`/`lap_active` ports, no snapshot register, and `digits` is always the live count.

## Structure
- Package `stopwatch_pkg`:
  - State enum `sw_state_t` {IDLE, RUN, PAUSED}.
  - `typedef logic [3:0] bcd_t`.
  - Constants `SEC_TENS_MAX`=5 and `DIGIT_MAX`=9.
- Sub-module `bcd_digit`: one BCD digit with parameterised max value.
  - Inputs: `inc`, `clr`.
  - Outputs: `value`, `carry`. `carry` is combinational: `inc` && value==max.
  - Instantiated four times, chained through carry.

## Test plan
- Reset mid-count at 12:34 in RUN → next cycle `digits`=16'h0000, `running`=0. Ticks are ignored until `start_stop`.
- `start_stop`, then 61 ticks → `digits`=16'h0101; 60th tick yields 16'h0100 (00:59→01:00 carry).
- `SATURATE`=0, preload to 59:59 by ticking, one more tick → 16'h0000, `rollover` high for one cycle, `running`=1.
- `SATURATE`=1, same sequence → stays 16'h5959, `rollover` one cycle, `running`=0. Extra tick leaves the count unchanged.
- `clear`+`start_stop` same cycle: in PAUSED at 00:07 → IDLE, 16'h0000, `running`=0. In RUN → PAUSED at 00:07.
- `STOPWATCH_LAP_EN`: at 00:05 pulse `lap`, give 3 ticks → `digits` holds 16'h0005, `lap_active`=1. `lap` again → 16'h0008 next cycle.
